// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that feeds the decoder. It holds the program counter
// and keeps at most one word read outstanding to instruction memory. Each
// returned word is handed to decode with its PC through a valid/ready
// handshake. Execute can redirect the PC. A halt from decode stops fetch for
// good; only reset leaves the halted state.
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a target that is not
//                            word-aligned halts fetch and raises misalign_err.
//                            When undefined, the low two target bits are
//                            cleared on load and misalign_err is held at 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   imem_req       one-cycle read request strobe
//   imem_addr      word-aligned read address (meaningful while imem_req=1)
//   imem_rvalid    read data valid, at least one cycle after imem_req
//   imem_rdata     instruction word, sampled while imem_rvalid=1
//   instr_o        instruction presented to decode (NOP_INSTR when not valid)
//   pc_o           address of instr_o
//   instr_valid    instr_o/pc_o valid
//   instr_ready    decode accepts instr_o this cycle
//   redirect_valid load redirect_pc into the PC
//   redirect_pc    redirect target
//   halt_i         halt request from decode (wins over a redirect)
//   halted_o       fetch permanently stopped
//   misalign_err   misaligned redirect trapped (build option only)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0100_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_i,
    output logic        halted_o,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        discard_reg, discard_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_out_reg, pc_out_next;
    logic        valid_reg, valid_next;
    logic        halted_reg, halted_next;
    logic        imem_req_reg;
    logic [31:0] imem_addr_reg;

    // Target actually loaded on a redirect, and whether the redirect traps.
    logic [31:0] redirect_target;
    logic        redirect_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_reg, mis_next;

    assign redirect_target = redirect_pc;
    assign redirect_bad    = |redirect_pc[1:0];
    assign misalign_err    = mis_reg;
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign redirect_bad    = 1'b0;
    assign misalign_err    = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        discard_next = discard_reg;
        instr_next   = instr_reg;
        pc_out_next  = pc_out_reg;
        valid_next   = valid_reg;
        halted_next  = halted_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_next     = mis_reg;
`endif

        if (state_reg == ST_HALTED) begin
            // Sticky until reset: every input is ignored.
            state_next = ST_HALTED;
        end else if (halt_i || (redirect_valid && redirect_bad)) begin
            // Any in-flight read is simply never looked at again.
            state_next  = ST_HALTED;
            valid_next  = 1'b0;
            instr_next  = NOP_INSTR;
            halted_next = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (!halt_i) begin
                mis_next = 1'b1;
            end
`endif
        end else begin
            // Normal fetch sequencing.
            case (state_reg)
                ST_IDLE: state_next = ST_REQ;
                ST_REQ:  state_next = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_reg) begin
                            // Response belongs to a fetch made before a redirect.
                            discard_next = 1'b0;
                            state_next   = ST_REQ;
                        end else begin
                            instr_next  = imem_rdata;
                            pc_out_next = pc_reg;
                            valid_next  = 1'b1;
                            pc_next     = pc_reg + 32'd4;
                            state_next  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        valid_next = 1'b0;
                        instr_next = NOP_INSTR;
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            // A redirect overrides the sequencing above. An instruction
            // accepted in HOLD on the same cycle has already been consumed.
            if (redirect_valid) begin
                pc_next    = redirect_target;
                valid_next = 1'b0;
                instr_next = NOP_INSTR;
                case (state_reg)
                    ST_REQ: begin
                        // The request just issued is now stale.
                        state_next   = ST_WAIT;
                        discard_next = 1'b1;
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            discard_next = 1'b0;
                            state_next   = ST_REQ;
                        end else begin
                            discard_next = 1'b1;
                            state_next   = ST_WAIT;
                        end
                    end
                    default: state_next = ST_REQ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= RESET_PC;
            discard_reg   <= 1'b0;
            instr_reg     <= NOP_INSTR;
            pc_out_reg    <= RESET_PC;
            valid_reg     <= 1'b0;
            halted_reg    <= 1'b0;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_reg       <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            discard_reg <= discard_next;
            instr_reg   <= instr_next;
            pc_out_reg  <= pc_out_next;
            valid_reg   <= valid_next;
            halted_reg  <= halted_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_reg     <= mis_next;
`endif
            // Request strobe is registered so it is high exactly for the
            // cycle the FSM spends in REQ, with the PC that REQ fetches.
            imem_req_reg <= (state_next == ST_REQ);
            if (state_next == ST_REQ) begin
                imem_addr_reg <= pc_next;
            end
        end
    end

    assign imem_req    = imem_req_reg;
    assign imem_addr   = imem_addr_reg;
    assign instr_o     = instr_reg;
    assign pc_o        = pc_out_reg;
    assign instr_valid = valid_reg;
    assign halted_o    = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Randomized bench for fetch_unit. A transaction-level model tracks the PC of
// the next instruction decode should see, which advances by 4 per accepted
// instruction and jumps on redirects, plus a halted flag. Instruction memory
// is a pure function of the address, so any delivered word can be checked
// against its PC. This exposes stale or misdirected data. A small memory agent
// answers each request after a random latency and also drives stray rvalid
// pulses while no read is outstanding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_i = 1'b0;
    logic        halted_o;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_i        (halt_i),
        .halted_o      (halted_o),
        .misalign_err  (misalign_err)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] exp_pc;
    bit          m_halted, m_mis, acc_prev;
    bit          prev_hold;
    logic [31:0] prev_instr, prev_pc;
    // Memory agent state
    bit          pend, inject_stale;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat_min, lat_max;
    // Stimulus knobs
    int          ready_pct, redir_pct;
    bit          do_halt, do_redir;
    logic [31:0] redir_ovr;
    // Bookkeeping
    int          cyc, stall, n_acc, n_req;
    bit          first_req_seen, last_req, watch_hit;
    logic [31:0] watch_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(TRAP ? 5 : 7))
            0: return RESET_PC + 32'h40;
            1: return 32'h0200_0000;
            2: return 32'hFFFF_FFF8;
            3: return 32'hFFFF_FFFC;
            4: return 32'h0000_1000;
            5: return {r[31:2], 2'b00};
            6: return 32'h0100_0042;
            default: return r;
        endcase
    endfunction

    task automatic check_reset_values();
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_instr_valid", instr_valid, 0);
        check_eq("rst_instr_o", instr_o, NOP);
        check_eq("rst_pc_o", pc_o, RESET_PC);
        check_eq("rst_halted_o", halted_o, 0);
        check_eq("rst_misalign_err", misalign_err, 0);
    endtask

    // Asserts reset a little after a rising edge (so it must act without a
    // clock), checks the cleared outputs, and releases it just after an edge
    // so the next sampled cycle is the IDLE cycle.
    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        imem_rvalid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; halt_i = 1'b0;
        exp_pc = RESET_PC; m_halted = 0; m_mis = 0; acc_prev = 0; prev_hold = 0;
        pend = 0; cyc = 0; stall = 0; first_req_seen = 0; last_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle: sample and check on the falling edge, drive the next
    // inputs, then advance the model by what the coming rising edge does.
    task automatic step();
        bit acc, rdr, hlt;
        @(negedge clk);
        check_eq("halted_o", halted_o, m_halted);
        check_eq("misalign_err", misalign_err, m_mis);
        if (m_halted) begin
            check_eq("halt_no_req", imem_req, 0);
            check_eq("halt_no_valid", instr_valid, 0);
        end
        if (instr_valid) begin
            check_eq("pc_o", pc_o, exp_pc);
            check_eq("instr_o", instr_o, mem_word(pc_o));
            check_eq("req_while_valid", imem_req, 0);
        end else begin
            check_eq("instr_o_nop", instr_o, NOP);
        end
        if (prev_hold) begin
            check_eq("hold_valid", instr_valid, 1);
            check_eq("hold_instr", instr_o, prev_instr);
            check_eq("hold_pc", pc_o, prev_pc);
        end
        if (acc_prev) check_eq("req_after_accept", imem_req, 1);
        last_req = imem_req;
        if (imem_req) begin
            n_req++;
            check_eq("imem_addr", imem_addr, exp_pc);
            if (!first_req_seen) begin
                check_eq("first_req_cycle", cyc, 1);
                first_req_seen = 1;
            end
            if (imem_addr == watch_addr) watch_hit = 1;
        end
        if (m_halted || imem_req || instr_valid) stall = 0;
        else stall++;
        if (stall == 12) check_eq("progress_timeout", stall, 0);

        // Memory agent
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (inject_stale) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD; inject_stale = 0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 0;
            end
        end
        if (imem_req) begin
            check_eq("one_outstanding", pend, 0);
            pend = 1; pend_cnt = $urandom_range(lat_max, lat_min); pend_addr = imem_addr;
        end else if (!pend && !imem_rvalid && $urandom_range(99) < 3) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        end

        // Decode / execute stimulus
        instr_ready    = ($urandom_range(99) < ready_pct);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (do_redir) begin
            redirect_valid = 1'b1; redirect_pc = redir_ovr; do_redir = 0;
        end else if ($urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1; redirect_pc = pick_target();
        end
        halt_i = do_halt; do_halt = 0;

        // Reference model for the coming edge
        acc = instr_valid && instr_ready;
        rdr = redirect_valid;
        hlt = halt_i;
        acc_prev   = 0;
        prev_hold  = instr_valid && !acc && !rdr && !hlt && !m_halted;
        prev_instr = instr_o;
        prev_pc    = pc_o;
        if (!m_halted) begin
            if (hlt) begin
                m_halted = 1;
            end else begin
                if (acc) begin
                    n_acc++;
                    $display("accept pc=%08h instr=%08h", pc_o, instr_o);
                    exp_pc   = exp_pc + 32'd4;
                    acc_prev = 1;
                end
                if (rdr) begin
                    if (TRAP && redirect_pc[1:0] != 2'b00) begin
                        m_halted = 1; m_mis = 1; acc_prev = 0;
                    end else begin
                        exp_pc = redirect_pc & 32'hFFFF_FFFC;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic run_until_req();
        int guard = 0;
        do begin
            step();
            guard++;
        end while (!last_req && guard < 50);
        check_eq("reach_req", last_req, 1);
    endtask

    initial begin
        int req_mark;
        lat_min = 1; lat_max = 1; ready_pct = 100; redir_pct = 0;
        do_halt = 0; do_redir = 0; inject_stale = 0; n_acc = 0; n_req = 0;
        watch_addr = 32'hFFFF_FFFF; watch_hit = 0;
        apply_reset();

        // First fetches at 1-cycle latency, decode always ready: 3-cycle spacing.
        repeat (8) step();
        check_eq("accepts_lat1", n_acc, 2);

        // Decode stalls in HOLD for several cycles, then accepts.
        ready_pct = 0;
        repeat (8) step();
        ready_pct = 100;
        repeat (4) step();

        // Redirect in WAIT; the stale response arrives two cycles later.
        lat_min = 3; lat_max = 3;
        run_until_req();
        do_redir = 1; redir_ovr = 32'h0100_0040;
        watch_addr = 32'h0100_0040; watch_hit = 0;
        repeat (12) step();
        check_eq("redirect_target_fetched", watch_hit, 1);

        // PC wrap from the top of the address space.
        lat_min = 1; lat_max = 1;
        run_until_req();
        do_redir = 1; redir_ovr = 32'hFFFF_FFFC;
        watch_addr = 32'h0000_0000; watch_hit = 0;
        repeat (12) step();
        check_eq("wrap_to_zero", watch_hit, 1);

        // Misaligned redirect target.
        run_until_req();
        do_redir = 1; redir_ovr = 32'h0100_0042;
        watch_addr = 32'h0100_0040; watch_hit = 0;
        repeat (8) step();
        if (TRAP) begin
            check_eq("trap_misalign_err", misalign_err, 1);
            check_eq("trap_halted", halted_o, 1);
            apply_reset();
        end else begin
            check_eq("misalign_aligned", watch_hit, 1);
        end

        // Randomized traffic.
        lat_min = 1; lat_max = 3; ready_pct = 60; redir_pct = 8;
        repeat (2000) step();

        // Reset in the middle of WAIT; a stale rvalid lands in the IDLE cycle.
        run_until_req();
        apply_reset();
        inject_stale = 1;
        repeat (200) step();

        // Halt together with a redirect: halt wins and is permanent.
        repeat (5) step();
        do_halt = 1; do_redir = 1; redir_ovr = 32'h0100_0080;
        step();
        req_mark = n_req;
        repeat (22) step();
        check_eq("reqs_after_halt", n_req - req_mark, 0);
        check_eq("halted_final", halted_o, 1);
        check_eq("valid_after_halt", instr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
